inta_sequencer: RTL and testbench

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/pic_pkg.sv | 16 +
 rtl/inta_edge_detect.sv | 20 ++
 rtl/inta_sequencer.sv | 131 +++++++++++++
 tb/tb_inta_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt-acknowledge logic.
// Holds the sequencer state encoding, CALL opcode and spurious level.
package pic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_P1,
    S_P2,
    S_P3
  } state_t;

  localparam logic [7:0] CALL_OP     = 8'hCD;
  localparam logic [2:0] SPURIOUS_ID = 3'd7;

endpackage

// File: rtl/inta_edge_detect.sv
// Registers the synchronized INTA strobe and flags its edges.
// INTA idles high, so the register resets to 1.
module inta_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic INTA,
  output logic INTA_q,
  output logic fall,
  output logic rise
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) INTA_q <= 1'b1;
    else          INTA_q <= INTA;
  end

  assign fall = INTA_q & ~INTA;
  assign rise = ~INTA_q & INTA;

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: raises INT, counts INTA pulses,
// drives vector/CALL bytes and pulses ISR set / auto-EOI.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       INTA,
  input  logic       int_request,
  input  logic [2:0] priority_id,
  input  logic       init_clear,
  input  logic       mode_8086,
  input  logic       auto_eoi,
  input  logic       adi,
  input  logic [4:0] vector_base,
  input  logic [2:0] addr_low,
  input  logic [7:0] addr_high,
  output logic       INT,
  output logic       freeze,
  output logic       isr_set,
  output logic [2:0] isr_id,
  output logic       eoi_auto,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  state_t     state, state_nxt;
  logic       INTA_q, fall, rise;
  logic       mode_q, mode_nxt;
  logic       spur_q, spur_nxt;
  logic [2:0] id_nxt;
  logic       set_nxt, eoi_nxt;

  inta_edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .INTA    (INTA),
    .INTA_q  (INTA_q),
    .fall    (fall),
    .rise    (rise)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      mode_q   <= 1'b0;
      spur_q   <= 1'b0;
      isr_id   <= 3'd0;
      isr_set  <= 1'b0;
      eoi_auto <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode_q   <= mode_nxt;
      spur_q   <= spur_nxt;
      isr_id   <= id_nxt;
      isr_set  <= set_nxt;
      eoi_auto <= eoi_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    spur_nxt  = spur_q;
    id_nxt    = isr_id;
    set_nxt   = 1'b0;
    eoi_nxt   = 1'b0;
    if (init_clear) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (int_request) state_nxt = S_PEND;
        end
        S_PEND: begin
          if (fall) begin
            state_nxt = S_P1;
            mode_nxt  = mode_8086;
            spur_nxt  = ~int_request;
            set_nxt   = int_request;
            id_nxt    = int_request ? priority_id : SPURIOUS_ID;
          end
        end
        S_P1: begin
          if (fall) state_nxt = S_P2;
        end
        S_P2: begin
          if (mode_q) begin
            if (rise) begin
              state_nxt = S_IDLE;
              eoi_nxt   = auto_eoi & ~spur_q;
            end
          end else if (fall) begin
            state_nxt = S_P3;
          end
        end
        S_P3: begin
          if (rise) begin
            state_nxt = S_IDLE;
            eoi_nxt   = auto_eoi & ~spur_q;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign INT    = (state == S_PEND);
  assign freeze = (state == S_P1) | (state == S_P2) | (state == S_P3);

  always_comb begin
    data_out    = 8'h00;
    data_out_en = 1'b0;
    if (mode_q) begin
      if (state == S_P2) begin
        data_out    = {vector_base, isr_id};
        data_out_en = ~INTA;
      end
    end else begin
      unique case (state)
        S_P1: data_out = CALL_OP;
        S_P2: data_out = adi ? {addr_low, isr_id, 2'b00}
                             : {addr_low[2:1], isr_id, 3'b000};
        S_P3: data_out = addr_high;
        default: data_out = 8'h00;
      endcase
      data_out_en = ~INTA & freeze;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: 8086/8080 acknowledge cycles,
// AEOI, spurious request, init_clear abort and mid-sequence reset.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       INTA;
  logic       int_request;
  logic [2:0] priority_id;
  logic       init_clear;
  logic       mode_8086;
  logic       auto_eoi;
  logic       adi;
  logic [4:0] vector_base;
  logic [2:0] addr_low;
  logic [7:0] addr_high;
  logic       INT;
  logic       freeze;
  logic       isr_set;
  logic [2:0] isr_id;
  logic       eoi_auto;
  logic [7:0] data_out;
  logic       data_out_en;

  int n_chk  = 0;
  int n_fail = 0;

  inta_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .INTA        (INTA),
    .int_request (int_request),
    .priority_id (priority_id),
    .init_clear  (init_clear),
    .mode_8086   (mode_8086),
    .auto_eoi    (auto_eoi),
    .adi         (adi),
    .vector_base (vector_base),
    .addr_low    (addr_low),
    .addr_high   (addr_high),
    .INT         (INT),
    .freeze      (freeze),
    .isr_set     (isr_set),
    .isr_id      (isr_id),
    .eoi_auto    (eoi_auto),
    .data_out    (data_out),
    .data_out_en (data_out_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 2ns after the edge, before inputs move.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n     = 1'b0;
    INTA        = 1'b1;
    int_request = 1'b0;
    priority_id = 3'd0;
    init_clear  = 1'b0;
    mode_8086   = 1'b1;
    auto_eoi    = 1'b0;
    adi         = 1'b1;
    vector_base = 5'b01000;
    addr_low    = 3'b101;
    addr_high   = 8'h12;
    #12;
    chk("rst_int", {7'd0, INT}, 8'd0);
    chk("rst_freeze", {7'd0, freeze}, 8'd0);
    chk("rst_isr_id", {5'd0, isr_id}, 8'd0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_en", {7'd0, data_out_en}, 8'd0);
    reset_n = 1'b1;
    tick();

    // 8086, id 3: two pulses, vector 0x43 in pulse 2 only
    int_request = 1'b1;
    priority_id = 3'd3;
    tick();
    chk("t1_int", {7'd0, INT}, 8'd1);
    INTA = 1'b0;
    tick();
    chk("t1_isr_set", {7'd0, isr_set}, 8'd1);
    chk("t1_isr_id", {5'd0, isr_id}, 8'd3);
    chk("t1_int_drop", {7'd0, INT}, 8'd0);
    chk("t1_freeze", {7'd0, freeze}, 8'd1);
    chk("t1_en_p1", {7'd0, data_out_en}, 8'd0);
    tick();
    chk("t1_set_pulse", {7'd0, isr_set}, 8'd0);
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
    int_request = 1'b0;
    tick();
    chk("t1_en_p2", {7'd0, data_out_en}, 8'd1);
    chk("t1_vec", data_out, 8'h43);
    INTA = 1'b1;
    tick();
    chk("t1_done_frz", {7'd0, freeze}, 8'd0);
    chk("t1_done_en", {7'd0, data_out_en}, 8'd0);
    chk("t1_no_eoi", {7'd0, eoi_auto}, 8'd0);
    tick();

    // 8080, adi=1, id 2: CD, A8, 12
    mode_8086   = 1'b0;
    int_request = 1'b1;
    priority_id = 3'd2;
    tick();
    INTA = 1'b0;
    tick();
    chk("t2_en1", {7'd0, data_out_en}, 8'd1);
    chk("t2_b1", data_out, 8'hCD);
    chk("t2_id", {5'd0, isr_id}, 8'd2);
    int_request = 1'b0;
    INTA = 1'b1;
    tick();
    chk("t2_en_hi", {7'd0, data_out_en}, 8'd0);
    INTA = 1'b0;
    tick();
    chk("t2_b2", data_out, 8'hA8);
    chk("t2_en2", {7'd0, data_out_en}, 8'd1);
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
    tick();
    chk("t2_b3", data_out, 8'h12);
    INTA = 1'b1;
    tick();
    chk("t2_idle_frz", {7'd0, freeze}, 8'd0);
    chk("t2_idle_int", {7'd0, INT}, 8'd0);
    chk("t2_idle_data", data_out, 8'h00);
    tick();

    // 8086 AEOI, id 5: eoi_auto at second rise, single pulse
    mode_8086   = 1'b1;
    auto_eoi    = 1'b1;
    int_request = 1'b1;
    priority_id = 3'd5;
    tick();
    INTA = 1'b0;
    tick();
    int_request = 1'b0;
    INTA = 1'b1;
    tick();
    chk("t3_no_eoi_r1", {7'd0, eoi_auto}, 8'd0);
    INTA = 1'b0;
    tick();
    chk("t3_vec", data_out, 8'h45);
    INTA = 1'b1;
    tick();
    chk("t3_eoi", {7'd0, eoi_auto}, 8'd1);
    chk("t3_id", {5'd0, isr_id}, 8'd5);
    tick();
    chk("t3_eoi_once", {7'd0, eoi_auto}, 8'd0);

    // Spurious: request drops before first INTA
    int_request = 1'b1;
    priority_id = 3'd1;
    tick();
    chk("t4_int", {7'd0, INT}, 8'd1);
    int_request = 1'b0;
    INTA = 1'b0;
    tick();
    chk("t4_no_set", {7'd0, isr_set}, 8'd0);
    chk("t4_id7", {5'd0, isr_id}, 8'd7);
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
    tick();
    chk("t4_vec", data_out, 8'h47);
    INTA = 1'b1;
    tick();
    chk("t4_no_eoi", {7'd0, eoi_auto}, 8'd0);
    chk("t4_idle", {7'd0, freeze}, 8'd0);
    auto_eoi = 1'b0;
    tick();

    // 8080 abort by init_clear in P2
    mode_8086   = 1'b0;
    auto_eoi    = 1'b1;
    int_request = 1'b1;
    priority_id = 3'd4;
    tick();
    INTA = 1'b0;
    tick();
    int_request = 1'b0;
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
    tick();
    chk("t5_p2_en", {7'd0, data_out_en}, 8'd1);
    chk("t5_p2_b", data_out, 8'hB0);
    init_clear = 1'b1;
    tick();
    init_clear = 1'b0;
    chk("t5_clr_en", {7'd0, data_out_en}, 8'd0);
    chk("t5_clr_frz", {7'd0, freeze}, 8'd0);
    chk("t5_clr_eoi", {7'd0, eoi_auto}, 8'd0);
    INTA = 1'b1;
    tick();
    chk("t5_rise_eoi", {7'd0, eoi_auto}, 8'd0);
    INTA = 1'b0;
    tick();
    chk("t5_ign_frz", {7'd0, freeze}, 8'd0);
    chk("t5_ign_set", {7'd0, isr_set}, 8'd0);
    chk("t5_ign_int", {7'd0, INT}, 8'd0);
    INTA = 1'b1;
    auto_eoi = 1'b0;
    tick();

    // Asynchronous reset in P1, then fresh request
    mode_8086   = 1'b1;
    int_request = 1'b1;
    priority_id = 3'd6;
    tick();
    INTA = 1'b0;
    tick();
    chk("t6_p1_set", {7'd0, isr_set}, 8'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_set", {7'd0, isr_set}, 8'd0);
    chk("t6_rst_id", {5'd0, isr_id}, 8'd0);
    chk("t6_rst_frz", {7'd0, freeze}, 8'd0);
    chk("t6_rst_int", {7'd0, INT}, 8'd0);
    @(negedge clk);
    INTA = 1'b1;
    reset_n = 1'b1;
    tick();
    chk("t6_int", {7'd0, INT}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
